// File: rtl/dco_tune_ctrl.sv
// Closed-loop DCO tuner: SAR search for the largest code whose osc period meets target, then +/-1 tracking.
// Latency: one measurement per SETTLE+1 osc edges (+2-3 clk sync); no backpressure, start ignored while busy.
module dco_tune_ctrl #(
  parameter int W      = 8,
  parameter int CW     = 16,
  parameter int SETTLE = 2,
  parameter int TOL    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic [CW-1:0] target,
  input  logic          osc,
  output logic [W-1:0]  maxVal,
  output logic [W-1:0]  duty,
  output logic          busy,
  output logic          locked,
  output logic [CW-1:0] meas_period,
  output logic          meas_valid
);

  localparam int            BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0]  CODE_MAX = '1;
  localparam logic [W-1:0]  CODE_MID = W'(1) << (W - 1);
  localparam logic [CW:0]   TOL_X    = (CW + 1)'(TOL);
  localparam logic [3:0]    SET_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE,
    S_TRACK
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  code, code_nxt;
  logic [BW-1:0] bit_idx, bit_nxt;
  logic [CW-1:0] tgt, tgt_nxt;
  logic [3:0]    settle_cnt, settle_nxt;
  logic          tracking, tracking_nxt;
  logic          locked_nxt;
  logic [CW-1:0] mp_nxt;
  logic          mv_nxt;

  logic          sync1, sync2;
  logic          osc_edge, meas_evt;
  logic [CW-1:0] cnt;

  logic [CW:0]   p_x, t_x;
  logic          sar_over, trk_hi, trk_lo;

  // Never drive the DCO with 0: that setting bypasses the divider.
  assign maxVal = (code == '0) ? W'(1) : code;
  assign duty   = {1'b0, maxVal[W-1:1]};
  assign busy   = (state != S_IDLE);

  assign osc_edge = sync1 & ~sync2;
  assign meas_evt = osc_edge | (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= CW'(1);
    end else begin
      sync1 <= osc;
      sync2 <= sync1;
      cnt   <= meas_evt ? CW'(1) : cnt + CW'(1);
    end
  end

  // Widened compare so target+TOL cannot wrap.
  assign p_x      = {1'b0, meas_period};
  assign t_x      = {1'b0, tgt};
  assign sar_over = p_x > t_x;
  assign trk_hi   = p_x > (t_x + TOL_X);
  assign trk_lo   = (p_x + TOL_X) < t_x;

  always_comb begin
    state_nxt    = state;
    code_nxt     = code;
    bit_nxt      = bit_idx;
    tgt_nxt      = tgt;
    settle_nxt   = settle_cnt;
    tracking_nxt = tracking;
    locked_nxt   = locked;
    mp_nxt       = meas_period;
    mv_nxt       = 1'b0;
    if (!enable) begin
      state_nxt  = S_IDLE;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          locked_nxt = 1'b0;
          if (start) begin
            tgt_nxt      = target;
            code_nxt     = CODE_MID;
            bit_nxt      = BW'(W - 1);
            settle_nxt   = '0;
            tracking_nxt = 1'b0;
            state_nxt    = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (meas_evt) begin
            if (!osc_edge || settle_cnt == SET_LAST) begin
              settle_nxt = '0;
              state_nxt  = S_MEASURE;
            end else begin
              settle_nxt = settle_cnt + 4'd1;
            end
          end
        end
        S_MEASURE: begin
          if (meas_evt) begin
            mp_nxt    = cnt;
            mv_nxt    = 1'b1;
            state_nxt = tracking ? S_TRACK : S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (sar_over) code_nxt[bit_idx] = 1'b0;
          if (bit_idx != '0) begin
            code_nxt[bit_idx - BW'(1)] = 1'b1;
            bit_nxt = bit_idx - BW'(1);
          end else begin
            tracking_nxt = 1'b1;
          end
          settle_nxt = '0;
          state_nxt  = S_SETTLE;
        end
        S_TRACK: begin
          state_nxt  = S_MEASURE;
          settle_nxt = '0;
          if (trk_hi) begin
            locked_nxt = 1'b0;
            if (code != '0) begin
              code_nxt  = code - W'(1);
              state_nxt = S_SETTLE;
            end
          end else if (trk_lo) begin
            locked_nxt = 1'b0;
            if (code != CODE_MAX) begin
              code_nxt  = code + W'(1);
              state_nxt = S_SETTLE;
            end
          end else begin
            locked_nxt = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      code        <= CODE_MID;
      bit_idx     <= BW'(W - 1);
      tgt         <= '0;
      settle_cnt  <= '0;
      tracking    <= 1'b0;
      locked      <= 1'b0;
      meas_period <= '0;
      meas_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      code        <= code_nxt;
      bit_idx     <= bit_nxt;
      tgt         <= tgt_nxt;
      settle_cnt  <= settle_nxt;
      tracking    <= tracking_nxt;
      locked      <= locked_nxt;
      meas_period <= mp_nxt;
      meas_valid  <= mv_nxt;
    end
  end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Directed bench for dco_tune_ctrl: DCO model with period maxVal+1(+extra), plus a CW=10 instance with osc stuck low.
module tb_dco_tune_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, start, osc;
  logic [15:0] target;
  logic [7:0]  max_val, duty;
  logic        busy, locked, mvalid;
  logic [15:0] mperiod;

  logic        enable2, start2;
  logic        osc2;
  logic [9:0]  target2;
  logic [7:0]  max_val2, duty2;
  logic        busy2, locked2, mvalid2;
  logic [9:0]  mperiod2;

  int total = 0;
  int bad   = 0;

  dco_tune_ctrl #(.W(8), .CW(16), .SETTLE(2), .TOL(1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .target(target), .osc(osc),
    .maxVal(max_val), .duty(duty), .busy(busy), .locked(locked),
    .meas_period(mperiod), .meas_valid(mvalid)
  );

  dco_tune_ctrl #(.W(8), .CW(10), .SETTLE(2), .TOL(1)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .start(start2), .target(target2), .osc(osc2),
    .maxVal(max_val2), .duty(duty2), .busy(busy2), .locked(locked2),
    .meas_period(mperiod2), .meas_valid(mvalid2)
  );

  // DCO model: one-clk high pulse at the start of every period of maxVal+1+extra clocks.
  int extra = 0;
  int mcnt  = 0;
  int per;
  always_comb per = int'(max_val) + 1 + extra;
  always @(posedge clk) mcnt <= (mcnt >= per - 1) ? 0 : mcnt + 1;
  assign osc  = (mcnt == 0);
  assign osc2 = 1'b0;

  task automatic wait_locked(input logic want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (locked === want) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_meas(input int n, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mvalid === 1'b1) seen++;
      if (seen == n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_meas2(input int n, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mvalid2 === 1'b1) seen++;
      if (seen == n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_maxval(input logic [7:0] v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (max_val === v) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (max_val !== 8'd128) begin bad++; $display("FAIL reset_maxval got=%0d want=128", max_val); end
    total++; if (duty !== 8'd64) begin bad++; $display("FAIL reset_duty got=%0d want=64", duty); end
    total++; if (busy !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b locked=%b want 0 0", busy, locked); end
    total++; if (mperiod !== 16'd0 || mvalid !== 1'b0) begin bad++; $display("FAIL reset_meas period=%0d valid=%b want 0 0", mperiod, mvalid); end
    total++; if (max_val2 !== 8'd128 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_dut2 maxval=%0d busy=%b want 128 0", max_val2, busy2); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Includes a start pulse while busy with a different target, which must be ignored.
  task automatic test_sar_lock();
    bit ok;
    enable = 1'b1;
    target = 16'd100;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sar_busy got=%b want=1", busy); end
    wait_meas(1, 5000, ok);
    total++; if (!ok || mperiod !== 16'd129) begin bad++; $display("FAIL sar_first_meas ok=%b got=%0d want=129", ok, mperiod); end
    target = 16'd200;
    pulse_start();
    wait_locked(1'b1, 20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sar_lock_timeout locked=%b want=1", locked); end
    total++; if (max_val !== 8'd99 || duty !== 8'd49) begin bad++; $display("FAIL sar_code maxval=%0d duty=%0d want 99 49", max_val, duty); end
    total++; if (mperiod !== 16'd100 || busy !== 1'b1) begin bad++; $display("FAIL sar_track period=%0d busy=%b want 100 1", mperiod, busy); end
  endtask

  task automatic test_track_retune();
    bit ok;
    extra = 2;
    wait_locked(1'b0, 5000, ok);
    total++; if (!ok) begin bad++; $display("FAIL retune_drop_timeout locked=%b want=0", locked); end
    total++; if (max_val !== 8'd98 || mperiod !== 16'd102) begin bad++; $display("FAIL retune_drop maxval=%0d period=%0d want 98 102", max_val, mperiod); end
    wait_locked(1'b1, 5000, ok);
    total++; if (!ok || max_val !== 8'd98 || mperiod !== 16'd101) begin bad++; $display("FAIL retune_relock ok=%b maxval=%0d period=%0d want 98 101", ok, max_val, mperiod); end
  endtask

  // enable falls together with a start pulse: controller idles and the start is dropped.
  task automatic test_enable_drop();
    enable = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL endrop_flags busy=%b locked=%b want 0 0", busy, locked); end
    total++; if (max_val !== 8'd98) begin bad++; $display("FAIL endrop_hold got=%0d want=98", max_val); end
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || max_val !== 8'd98) begin bad++; $display("FAIL endrop_idle busy=%b maxval=%0d want 0 98", busy, max_val); end
  endtask

  task automatic test_saturate();
    bit ok;
    extra  = 0;
    target = 16'd1000;
    pulse_start();
    wait_meas(10, 30000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_meas_timeout ok=%b want=1", ok); end
    total++; if (max_val !== 8'd255 || duty !== 8'd127) begin bad++; $display("FAIL sat_code maxval=%0d duty=%0d want 255 127", max_val, duty); end
    total++; if (mperiod !== 16'd256 || locked !== 1'b0) begin bad++; $display("FAIL sat_track period=%0d locked=%b want 256 0", mperiod, locked); end
    wait_meas(1, 2000, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || max_val !== 8'd255 || locked !== 1'b0) begin bad++; $display("FAIL sat_nowrap ok=%b maxval=%0d locked=%b want 255 0", ok, max_val, locked); end
  endtask

  task automatic test_reset_mid_sar();
    bit ok;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    target = 16'd100;
    pulse_start();
    wait_maxval(8'd112, 20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_reach got=%0d want=112", max_val); end
    reset = 1'b1;
    #1;
    total++; if (max_val !== 8'd128 || duty !== 8'd64) begin bad++; $display("FAIL rst_mid_code maxval=%0d duty=%0d want 128 64", max_val, duty); end
    total++; if (busy !== 1'b0 || locked !== 1'b0 || mperiod !== 16'd0) begin bad++; $display("FAIL rst_mid_flags busy=%b locked=%b period=%0d want 0 0 0", busy, locked, mperiod); end
    @(negedge clk);
    reset  = 1'b0;
    target = 16'd50;
    @(negedge clk);
    pulse_start();
    wait_locked(1'b1, 20000, ok);
    total++; if (!ok || max_val !== 8'd49 || duty !== 8'd24 || mperiod !== 16'd50) begin bad++; $display("FAIL rst_rerun ok=%b maxval=%0d duty=%0d period=%0d want 49 24 50", ok, max_val, duty, mperiod); end
  endtask

  task automatic test_timeout();
    bit ok;
    enable2 = 1'b1;
    target2 = 10'd100;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_meas2(1, 3000, ok);
    total++; if (!ok || mperiod2 !== 10'd1023) begin bad++; $display("FAIL tmo_first ok=%b period=%0d want 1023", ok, mperiod2); end
    wait_meas2(8, 25000, ok);
    total++; if (!ok || mperiod2 !== 10'd1023) begin bad++; $display("FAIL tmo_ninth ok=%b period=%0d want 1023", ok, mperiod2); end
    total++; if (max_val2 !== 8'd1 || duty2 !== 8'd0) begin bad++; $display("FAIL tmo_code maxval=%0d duty=%0d want 1 0", max_val2, duty2); end
    total++; if (busy2 !== 1'b1 || locked2 !== 1'b0) begin bad++; $display("FAIL tmo_flags busy=%b locked=%b want 1 0", busy2, locked2); end
    wait_meas2(1, 3000, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || max_val2 !== 8'd1 || busy2 !== 1'b1) begin bad++; $display("FAIL tmo_floor ok=%b maxval=%0d busy=%b want 1 1", ok, max_val2, busy2); end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    start   = 1'b0;
    target  = '0;
    enable2 = 1'b0;
    start2  = 1'b0;
    target2 = '0;
    test_reset();
    test_sar_lock();
    test_track_retune();
    test_enable_drop();
    test_saturate();
    test_reset_mid_sar();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dco_tune_ctrl.md
Name: dco_tune_ctrl

Overview:
Closed-loop tuning controller for the W-bit digital controlled oscillator. It drives the DCO's maxVal/duty configuration and measures the period of the returned oscillation in clk cycles. A successive-approximation (SAR) search finds the code whose period best meets a target, then a tracking loop trims the code ±1 to hold lock. It sits between neuron configuration logic (target period, start) and the DCO instance.

Parameters:
W, 8, DCO control word width (maxVal/duty width)
CW, 16, period measurement counter width (clk cycles)
SETTLE, 2, osc rising edges discarded after every code update (1..15)
TOL, 1, lock tolerance in clk cycles

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 0 forces IDLE, code held
start  input  1  pulse; begins SAR search from IDLE
target  input  CW  desired osc period in clk cycles, captured on accepted start
osc  input  1  DCO output, may be asynchronous to clk
maxVal  output  W  DCO cycle code
duty  output  W  DCO duty code, always maxVal>>1
busy  output  1  high in any state other than IDLE
locked  output  1  tracking and last measurement within TOL
meas_period  output  CW  last measured period
meas_valid  output  1  1-cycle pulse when meas_period updates

Behaviour:
- Reset values: maxVal=2^(W-1), duty=2^(W-2), busy=0, locked=0, meas_period=0, meas_valid=0, state IDLE, internal code=2^(W-1).
- Applied code: maxVal = max(code,1), so the DCO never runs at maxVal=0 (avoids osc=clk bypass). duty updates in the same cycle as maxVal.
- osc passes through a 2-FF synchronizer; edge = sync1 & ~sync2. Edge detection latency: 2-3 clk.
- Period counter: cleared to 1 on each edge, +1 per clk otherwise; measured P = counter value at the next edge. If the counter reaches 2^CW-1 with no edge, the result is a timeout: P=2^CW-1. A timeout in SETTLE ends SETTLE.
- States: IDLE, SETTLE, MEASURE, DECIDE, TRACK.
- IDLE: start && enable -> latch target, code = 1<<(W-1), bit=W-1, go SETTLE. start is ignored when busy.
- SETTLE: count SETTLE edges, then go MEASURE. The counter is re-armed at the final settle edge.
- MEASURE: on the next edge or timeout, capture P into meas_period, pulse meas_valid, go DECIDE.
- DECIDE, SAR phase (bit>=0): if P>target, clear code[bit]. If bit>0, set code[bit-1], bit--, go SETTLE. If bit==0, enter TRACK phase via SETTLE. Result: the largest code with P<=target, or 0 (applied as 1).
- DECIDE, TRACK phase: if P>target+TOL, code-- (saturate at 0) and locked=0. If P+TOL<target, code++ (saturate at 2^W-1) and locked=0. Otherwise locked=1 and code is unchanged. Go SETTLE only if code changed; otherwise go directly to MEASURE.
- Comparisons use CW+1-bit arithmetic, with no wrap on target+TOL.
- locked is cleared on entering IDLE and on any out-of-tolerance TRACK measurement.
- enable=0 in any state: next cycle IDLE, busy=0, locked=0, code/maxVal held.
- reset mid-operation: all outputs return to their reset values immediately (asynchronous).
- A start coincident with enable falling is ignored.

Test Plan:
- Bench DCO model period=maxVal+1. target=100, start -> 8 SAR decisions, code 99 (maxVal=99, duty=49), TRACK P=100 -> locked=1, busy=1.
- target=1000 (exceeds max period 256) -> SAR ends at code 255. TRACK saturates at 255 with no wrap to 0; locked stays 0.
- After lock at 99, switch model to period=maxVal+3 -> P=102 drops locked, code 98, P=101 -> locked=1 again.
- osc tied 0, CW=10 -> every measurement times out with meas_period=1023. All bits cleared, maxVal=1, locked=0, busy stays 1.
- Assert reset mid-SAR (bit=4) -> maxVal=128, duty=64, busy=0, locked=0 in the same cycle. A fresh start re-runs the full search.
- enable low during TRACK -> IDLE next cycle, busy=0, locked=0, maxVal held. start while busy is ignored (target unchanged).
